// File: rtl/sg_arb_pkg.sv
// Shared types and defaults for the segmented-resource round-robin arbiter.
package sg_arb_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GRANT   = 3'd1,
        HOLD    = 3'd2,
        RELEASE = 3'd3,
        ERR     = 3'd4
    } ArbStates;

    localparam int unsigned DEF_N        = 32'd3;
    localparam int unsigned DEF_IDW      = 32'd2;
    localparam int unsigned DEF_MAX_HOLD = 32'd4;

    // States in which the current owner drives the resource.
    function automatic logic is_owned(input ArbStates s);
        return (s == GRANT) || (s == HOLD);
    endfunction

endpackage

// File: rtl/sg_rr_pick.sv
// Combinational round-robin picker: first requester after the current owner,
// searching owner+1, owner+2, ... modulo N.
module sg_rr_pick
    import sg_arb_pkg::*;
#(
    parameter int unsigned N   = DEF_N,
    parameter int unsigned IDW = DEF_IDW
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] owner,
    output logic           any,
    output logic [IDW-1:0] next_owner
);

    // Scan all N positions starting just after the current owner.
    always_comb begin
        logic [IDW-1:0] idx_v;
        any        = 1'b0;
        next_owner = owner;
        idx_v      = owner;
        for (int unsigned i = 32'd1; i <= N; i++) begin
            idx_v = IDW'((32'(owner) + i) % N);
            if (!any && req[idx_v]) begin
                any        = 1'b1;
                next_owner = idx_v;
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/sg_arbiter.sv
// Round-robin arbiter for one shared resource; protocol violations trap in ERR.
// Define SG_ARB_TIMEOUT_EN to bound HOLD to MAX_HOLD cycles.
module sg_arbiter
    import sg_arb_pkg::*;
#(
    parameter int unsigned N        = DEF_N,
    parameter int unsigned IDW      = DEF_IDW,
    parameter int unsigned MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [N-1:0]   req,
    input  logic           done,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] owner,
    output logic           busy,
    output logic           err
);

    if ((N < 32'd2) || (IDW < $clog2(N)) || (MAX_HOLD < 32'd1)) begin : g_bad_cfg
        $error("sg_arbiter: unsupported parameter set");
    end

    function automatic logic [N-1:0] idx_onehot(input logic [IDW-1:0] idx);
        logic [N-1:0] v;
        v      = {N{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

    ArbStates       state_r, next_state_s;
    logic [IDW-1:0] owner_r, next_owner_s, pick_owner_s;
    logic           pick_any_s, timeout_s;
    logic [N-1:0]   grant_r, grant_nx_s;
    logic           busy_r, busy_nx_s, err_r, err_nx_s;

`ifdef SG_ARB_TIMEOUT_EN
    localparam int unsigned HCW = (MAX_HOLD > 32'd1) ? $clog2(MAX_HOLD) : 32'd1;
    logic [HCW-1:0] hold_cnt_r, hold_cnt_nx_s;
    assign timeout_s = (hold_cnt_r == HCW'(MAX_HOLD - 32'd1));
`else
    assign timeout_s = 1'b0;
`endif

    sg_rr_pick #(.N(N), .IDW(IDW)) u_pick (
        .req        (req),
        .owner      (owner_r),
        .any        (pick_any_s),
        .next_owner (pick_owner_s)
    );

    // State, owner pointer and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            owner_r <= IDW'(N - 32'd1);
            grant_r <= {N{1'b0}};
            busy_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= next_state_s;
            owner_r <= next_owner_s;
            grant_r <= grant_nx_s;
            busy_r  <= busy_nx_s;
            err_r   <= err_nx_s;
        end
    end

`ifdef SG_ARB_TIMEOUT_EN
    // Count of HOLD cycles spent without done.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_cnt_r <= {HCW{1'b0}};
        end else begin
            hold_cnt_r <= hold_cnt_nx_s;
        end
    end
`endif

    // Next-state and owner selection.
    always_comb begin
        next_state_s = state_r;
        next_owner_s = owner_r;
`ifdef SG_ARB_TIMEOUT_EN
        hold_cnt_nx_s = hold_cnt_r;
`endif
        case (state_r)
            IDLE: begin
                if (pick_any_s) begin
                    next_state_s = GRANT;
                    next_owner_s = pick_owner_s;
`ifdef SG_ARB_TIMEOUT_EN
                    hold_cnt_nx_s = {HCW{1'b0}};
`endif
                end else begin
                    next_state_s = IDLE;
                end
            end
            GRANT:   next_state_s = HOLD;
            HOLD: begin
                if (done) begin
                    next_state_s = RELEASE;
                end else if (!req[owner_r]) begin
                    next_state_s = ERR;
                end else if (timeout_s) begin
                    next_state_s = ERR;
                end else begin
                    next_state_s = HOLD;
`ifdef SG_ARB_TIMEOUT_EN
                    hold_cnt_nx_s = hold_cnt_r + HCW'(1);
`endif
                end
            end
            RELEASE: next_state_s = IDLE;
            ERR:     next_state_s = ERR;
            default: next_state_s = ERR;
        endcase
    end

    // Output values to be registered alongside the next state.
    always_comb begin
        grant_nx_s = {N{1'b0}};
        if (is_owned(next_state_s)) begin
            grant_nx_s = idx_onehot(next_owner_s);
        end else begin
            grant_nx_s = {N{1'b0}};
        end
        busy_nx_s = (next_state_s != IDLE);
        err_nx_s  = (next_state_s == ERR);
    end

    assign grant = grant_r;
    assign owner = owner_r;
    assign busy  = busy_r;
    assign err   = err_r;

endmodule

// File: tb/tb_sg_arbiter.sv
// Self-checking bench for sg_arbiter: vector table, directed corner cases,
// and randomized traffic against a transaction-level reference model.
module tb_sg_arbiter;

    localparam int N        = 3;
    localparam int IDW      = 2;
    localparam int MAX_HOLD = 4;
`ifdef SG_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic           clock;
    logic           reset;
    logic [N-1:0]   req;
    logic           done;
    logic [N-1:0]   grant;
    logic [IDW-1:0] owner;
    logic           busy;
    logic           err;

    int pass_cnt  = 0;
    int total_cnt = 0;

    sg_arbiter #(.N(N), .IDW(IDW), .MAX_HOLD(MAX_HOLD)) dut (
        .clock (clock),
        .reset (reset),
        .req   (req),
        .done  (done),
        .grant (grant),
        .owner (owner),
        .busy  (busy),
        .err   (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: ownership age (-1 none, 0 grant cycle, k = k-th hold
    // cycle), a pending-release flag and a dead flag.
    int m_owner;
    int m_age;
    bit m_rel;
    bit m_dead;

    function automatic void m_reset();
        m_owner = N - 1;
        m_age   = -1;
        m_rel   = 1'b0;
        m_dead  = 1'b0;
    endfunction

    function automatic void m_step(input logic [N-1:0] r, input logic d);
        int c;
        bit found;
        if (m_dead) return;
        if (m_rel) begin
            m_rel = 1'b0;
            return;
        end
        if (m_age < 0) begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                c = (m_owner + k) % N;
                if (!found && r[c]) begin
                    found   = 1'b1;
                    m_owner = c;
                    m_age   = 0;
                end
            end
            return;
        end
        if (m_age == 0) begin
            m_age = 1;
            return;
        end
        if (d) begin
            m_age = -1;
            m_rel = 1'b1;
        end else if (!r[m_owner]) begin
            m_age  = -1;
            m_dead = 1'b1;
        end else if (TO_EN && m_age >= MAX_HOLD) begin
            m_age  = -1;
            m_dead = 1'b1;
        end else begin
            m_age = m_age + 1;
        end
    endfunction

    task automatic check(input string name, input logic [N-1:0] eg, input logic [IDW-1:0] eo,
                         input logic eb, input logic ee);
        total_cnt++;
        if (grant === eg && owner === eo && busy === eb && err === ee) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s @%0t: got grant=%b owner=%0d busy=%b err=%b, want grant=%b owner=%0d busy=%b err=%b",
                     name, $time, grant, owner, busy, err, eg, eo, eb, ee);
        end
    endtask

    task automatic check_model(input string name);
        logic [N-1:0] eg;
        eg = '0;
        if (!m_dead && m_age >= 0) eg[m_owner] = 1'b1;
        check(name, eg, IDW'(m_owner), m_dead || m_rel || (m_age >= 0), m_dead);
    endtask

    task automatic step_model(input string name);
        @(posedge clock);
        m_step(req, done);
        #1;
        check_model(name);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        m_reset();
        #2;
        check_model("reset_pulse");
        reset = 1'b0;
    endtask

    typedef struct {
        logic [N-1:0]   req;
        logic           done;
        logic [N-1:0]   grant;
        logic [IDW-1:0] owner;
        logic           busy;
        logic           err;
    } vec_t;

    vec_t tbl [19];

    initial begin
        int first_err;
        logic [N-1:0] r;

        // Alternation with done on the 2nd HOLD cycle, then done held high.
        tbl[0]  = '{3'b101, 1'b0, 3'b001, 2'd0, 1'b1, 1'b0};
        tbl[1]  = '{3'b101, 1'b0, 3'b001, 2'd0, 1'b1, 1'b0};
        tbl[2]  = '{3'b101, 1'b0, 3'b001, 2'd0, 1'b1, 1'b0};
        tbl[3]  = '{3'b101, 1'b1, 3'b000, 2'd0, 1'b1, 1'b0};
        tbl[4]  = '{3'b101, 1'b0, 3'b000, 2'd0, 1'b0, 1'b0};
        tbl[5]  = '{3'b101, 1'b0, 3'b100, 2'd2, 1'b1, 1'b0};
        tbl[6]  = '{3'b101, 1'b0, 3'b100, 2'd2, 1'b1, 1'b0};
        tbl[7]  = '{3'b101, 1'b0, 3'b100, 2'd2, 1'b1, 1'b0};
        tbl[8]  = '{3'b101, 1'b1, 3'b000, 2'd2, 1'b1, 1'b0};
        tbl[9]  = '{3'b101, 1'b0, 3'b000, 2'd2, 1'b0, 1'b0};
        tbl[10] = '{3'b101, 1'b0, 3'b001, 2'd0, 1'b1, 1'b0};
        tbl[11] = '{3'b101, 1'b0, 3'b001, 2'd0, 1'b1, 1'b0};
        tbl[12] = '{3'b101, 1'b1, 3'b000, 2'd0, 1'b1, 1'b0};
        tbl[13] = '{3'b101, 1'b1, 3'b000, 2'd0, 1'b0, 1'b0};
        tbl[14] = '{3'b101, 1'b1, 3'b100, 2'd2, 1'b1, 1'b0};
        tbl[15] = '{3'b101, 1'b1, 3'b100, 2'd2, 1'b1, 1'b0};
        tbl[16] = '{3'b101, 1'b1, 3'b000, 2'd2, 1'b1, 1'b0};
        tbl[17] = '{3'b000, 1'b0, 3'b000, 2'd2, 1'b0, 1'b0};
        tbl[18] = '{3'b000, 1'b0, 3'b000, 2'd2, 1'b0, 1'b0};

        reset = 1'b1;
        req   = '0;
        done  = 1'b0;
        m_reset();
        #12;
        check("reset_state", 3'b000, 2'd2, 1'b0, 1'b0);
        reset = 1'b0;
        repeat (10) step_model("idle_quiet");

        do_reset();
        for (int i = 0; i < 19; i++) begin
            req  = tbl[i].req;
            done = tbl[i].done;
            @(posedge clock);
            #1;
            check($sformatf("vec%0d", i), tbl[i].grant, tbl[i].owner, tbl[i].busy, tbl[i].err);
        end

        // Owner drops its request mid-HOLD: trap in ERR, absorbing.
        do_reset();
        req = 3'b010;
        step_model("drop_grant");
        step_model("drop_hold");
        req = 3'b000;
        step_model("drop_to_err");
        check("drop_err_hand", 3'b000, 2'd1, 1'b1, 1'b1);
        req = 3'b111;
        done = 1'b1;
        repeat (5) step_model("err_absorb");
        done = 1'b0;

        // Continuous hold without done.
        do_reset();
        req = 3'b001;
        first_err = 0;
        for (int i = 1; i <= 22; i++) begin
            step_model("hold_run");
            if (err === 1'b1 && first_err == 0) first_err = i;
        end
        total_cnt++;
        if (first_err == (TO_EN ? 6 : 0)) pass_cnt++;
        else $display("FAIL timeout_step: got first err at step %0d, want %0d", first_err, TO_EN ? 6 : 0);

        // Asynchronous reset in the middle of HOLD for owner 2.
        do_reset();
        req = 3'b100;
        step_model("own2_grant");
        step_model("own2_hold");
        check("own2_hand", 3'b100, 2'd2, 1'b1, 1'b0);
        reset = 1'b1;
        #1;
        m_reset();
        check("async_drop", 3'b000, 2'd2, 1'b0, 1'b0);
        #1;
        reset = 1'b0;
        req = 3'b111;
        step_model("post_reset_grant");
        check("post_reset_hand", 3'b001, 2'd0, 1'b1, 1'b0);

        // Randomized traffic against the reference model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                reset = 1'b1;
                m_reset();
                #1;
                check_model("rand_reset");
                reset = 1'b0;
            end
            r = 3'($urandom_range(0, 7));
            if (!m_dead && m_age >= 0 && $urandom_range(0, 19) != 0) r[m_owner] = 1'b1;
            req  = r;
            done = ($urandom_range(0, 3) == 0);
            step_model("random");
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
